// File: rtl/imem_fetch_arbiter.sv
// Shares a 4096x8 synchronous instruction RAM between 32-bit big-endian fetches and loader byte writes.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to trap misaligned fetches instead of reading them.
module imem_fetch_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int FAIR_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [31:0]       fetch_inst,
   output logic              fetch_err,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              ld_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   localparam int SW = $clog2(FAIR_MAX + 1);
   localparam logic [SW-1:0] FAIR_LIM = SW'(FAIR_MAX);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_TAIL, S_WR} state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [23:0]       bytes_q, bytes_d;
   logic [31:0]       inst_q, inst_d;
   logic              valid_q, valid_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              ld_win;
   logic              mis;
   logic              trap_q, trap_d;
   logic              unused_fetch_hi;

   // Address bits above the RAM are don't-care for fetches.
   assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

   assign ld_win = ld_req & (streak_q < FAIR_LIM);

`ifdef IMEM_MISALIGN_TRAP_EN
   logic err_q, err_d;

   assign mis       = (fetch_addr[1:0] != 2'b00);
   assign fetch_err = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         trap_q <= trap_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      trap_d = trap_q;
      err_d  = err_q;
      if (state_q == S_IDLE && fetch_req && !ld_win) trap_d = mis;
      if (state_q == S_TAIL) begin
         err_d  = trap_q;
         trap_d = 1'b0;
      end
   end
`else
   assign mis       = 1'b0;
   assign fetch_err = 1'b0;
   assign trap_q    = 1'b0;
   assign trap_d    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ld_win)         state_d = S_WR;
            else if (fetch_req) state_d = mis ? S_TAIL : S_RD;
         end
         S_RD:    if (cnt_q == 2'd3) state_d = S_TAIL;
         S_TAIL:  state_d = S_IDLE;
         S_WR:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 8'h00;
      ld_ack      = 1'b0;
      fetch_ready = 1'b0;
      busy        = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: fetch_ready = fetch_req & ~ld_win;
         S_RD: begin
            mem_en   = 1'b1;
            mem_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
         end
         S_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            ld_ack    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= 2'd0;
         base_q   <= '0;
         bytes_q  <= 24'h0;
         inst_q   <= 32'h0;
         valid_q  <= 1'b0;
         streak_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         bytes_q  <= bytes_d;
         inst_q   <= inst_d;
         valid_q  <= valid_d;
         streak_q <= streak_d;
      end
   end

   // Datapath: byte n arrives the cycle after its read, so RD cnt>0 and RD_TAIL capture.
   always_comb begin
      cnt_d   = cnt_q;
      base_d  = base_q;
      bytes_d = bytes_q;
      inst_d  = inst_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fetch_req && !ld_win) begin
               base_d = fetch_addr[ADDR_W-1:0];
               cnt_d  = 2'd0;
            end
         end
         S_RD: begin
            if (cnt_q != 2'd0) bytes_d = {bytes_q[15:0], mem_rdata};
            cnt_d = cnt_q + 2'd1;
         end
         S_TAIL: begin
            valid_d = 1'b1;
            inst_d  = trap_q ? 32'h0 : {bytes_q, mem_rdata};
         end
         default: ;
      endcase
   end

   // Loader streak only counts grants that actually made a pending fetch wait.
   always_comb begin
      streak_d = streak_q;
      if (!fetch_req)
         streak_d = '0;
      else if (state_q == S_IDLE)
         streak_d = ld_win ? streak_q + 1'b1 : '0;
   end

   assign fetch_valid = valid_q;
   assign fetch_inst  = inst_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized scoreboard bench for imem_fetch_arbiter: a byte-array reference memory predicts
// every fetched word, its read addresses and its latency; directed cases cover wrap, aliasing, fairness, reset.
module tb_imem_fetch_arbiter;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req = 1'b0;
   logic [31:0]   fetch_addr = '0;
   logic          fetch_ready, fetch_valid, fetch_err;
   logic [31:0]   fetch_inst;
   logic          ld_req = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [7:0]    ld_data = '0;
   logic          ld_ack, mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   imem_fetch_arbiter #(.ADDR_W(AW), .FAIR_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // The RAM macro the DUT drives
   logic [7:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [31:0] word;
      logic        err;
      int          due;
   } exp_t;

   logic [7:0]    ref_mem [0:4095];
   exp_t          exp_q[$];
   logic [AW-1:0] addr_q[$];
   logic [31:0]   last_inst = '0;
   logic          rec = 1'b0;
   string         order = "";
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [31:0]   w;
      logic [AW-1:0] a;
      exp_t          e;
      if (!reset) begin
         exp_q.delete();
         addr_q.delete();
         last_inst = '0;
      end else begin
         if (ld_ack) begin
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, ld_addr);
            chk("wr_data", mem_wdata, ld_data);
            ref_mem[ld_addr] = ld_data;
            if (rec) order = {order, "L"};
         end else begin
            chk("idle_we", mem_we, 0);
            chk("idle_wdata", mem_wdata, 0);
         end
         if (mem_en && !mem_we) begin
            chk("rd_expected", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) chk("rd_addr", mem_addr, addr_q.pop_front());
         end
         if (fetch_valid) begin
            chk("valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("fetch_inst", fetch_inst, e.word);
               chk("fetch_err", fetch_err, e.err);
               chk("latency", cyc, e.due);
               last_inst = e.word;
            end
         end
         chk("inst_hold", fetch_inst, last_inst);
         if (fetch_req && fetch_ready) begin
            if (rec) order = {order, "F"};
`ifdef IMEM_MISALIGN_TRAP_EN
            if (fetch_addr[1:0] != 2'b00) begin
               exp_q.push_back('{word: 32'h0, err: 1'b1, due: cyc + 2});
            end else
`endif
            begin
               w = '0;
               for (int i = 0; i < 4; i++) begin
                  a = fetch_addr[AW-1:0] + AW'(i);
                  addr_q.push_back(a);
                  w = {w[23:0], ref_mem[a]};
               end
               exp_q.push_back('{word: w, err: 1'b0, due: cyc + 6});
            end
         end
      end
   end

   // Caller sits just after a rising edge; returns just after the edge following the ack.
   task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d, input bit hold);
      bit got = 0;
      ld_req = 1'b1; ld_addr = a; ld_data = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ld_ack) begin got = 1; break; end
      end
      if (!got) chk("ld_timeout", got, 1);
      @(posedge clk); #1;
      if (!hold) ld_req = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input bit hold);
      bit got = 0;
      fetch_req = 1'b1; fetch_addr = a;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fetch_ready) begin got = 1; break; end
      end
      if (!got) chk("fetch_timeout", got, 1);
      @(posedge clk); #1;
      if (!hold) fetch_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", n < 200, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", fetch_ready, 0);
      chk("rst_valid", fetch_valid, 0);
      chk("rst_inst", fetch_inst, 0);
      chk("rst_err", fetch_err, 0);
      chk("rst_ack", ld_ack, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Boot image word and first fetch
      ld_write(12'h000, 8'h00, 0);
      ld_write(12'h001, 8'h50, 0);
      ld_write(12'h002, 8'h00, 0);
      ld_write(12'h003, 8'h93, 0);
      fetch(32'h0, 0);
      drain();
      chk("t1_word", fetch_inst, 32'h00500093);

      // Word straddling the top of memory
      ld_write(12'hFFE, 8'hAA, 0);
      ld_write(12'hFFF, 8'hBB, 0);
      ld_write(12'h000, 8'hCC, 0);
      ld_write(12'h001, 8'hDD, 0);
      fetch(32'h0000_0FFE, 0);
      drain();
`ifndef IMEM_MISALIGN_TRAP_EN
      chk("t2_wrap", fetch_inst, 32'hAABBCCDD);
`endif
      ld_write(12'h000, 8'h00, 0);
      ld_write(12'h001, 8'h50, 0);

      // High fetch address bits alias onto the RAM
      ld_write(12'h004, 8'h11, 0);
      ld_write(12'h005, 8'h22, 0);
      ld_write(12'h006, 8'h33, 0);
      ld_write(12'h007, 8'h44, 0);
      fetch(32'h0001_0004, 0);
      drain();
      chk("t4_alias", fetch_inst, 32'h11223344);

      // Reset in the middle of a word (RD, cnt=2)
      fetch(32'h0, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_mem_en", mem_en, 0);
      chk("t5_busy", busy, 0);
      chk("t5_valid", fetch_valid, 0);
      chk("t5_inst", fetch_inst, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      fetch(32'h0, 0);
      drain();
      chk("t5_word", fetch_inst, 32'h00500093);

`ifdef IMEM_MISALIGN_TRAP_EN
      fetch(32'h2, 0);
      drain();
      chk("t6_inst", fetch_inst, 32'h0);
`endif

      // Fairness: both requesters held continuously
      rec = 1'b1;
      order = "";
      fork
         begin
            for (int i = 0; i < 10; i++) ld_write(12'h100 + 12'(i), 8'($urandom), 1);
            ld_req = 1'b0;
         end
         begin
            for (int j = 0; j < 2; j++) fetch(32'h100 + 32'(4 * j), 1);
            fetch_req = 1'b0;
         end
      join
      rec = 1'b0;
      drain();
      n_cmp++;
      if (order != "LLLLFLLLLFLL") begin
         n_bad++;
         $display("FAIL t3_order: got %s want LLLLFLLLLFLL", order);
      end

      // Random concurrent traffic over a small window including the wrap point
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [AW-1:0] a;
               a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15))
                                               : (12'hFF0 | AW'($urandom_range(0, 15)));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               ld_write(a, 8'($urandom), 0);
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               logic [31:0] fa;
               fa = $urandom;
               fa[11:0] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 15))
                                                      : (12'hFF0 | 12'($urandom_range(0, 15)));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               fetch(fa, 0);
            end
         end
      join
      drain();
      chk("final_queue", exp_q.size() + addr_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
